// File: rtl/bsm_pkg.sv
// ============================================================================
// Module      : bsm_pkg
// Description : Shared types and helpers for the bit-serial MAC controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ACCUM = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [1:0] PREC_FULL  = 2'b00;
    localparam logic [1:0] PREC_HALF  = 2'b01;
    localparam logic [1:0] PREC_QUART = 2'b10;

    function automatic int nbits(input logic [1:0] prec, input int wgt_w);
        case (prec)
            PREC_HALF:  return wgt_w / 2;
            PREC_QUART: return wgt_w / 4;
            default:    return wgt_w;
        endcase
    endfunction

    // Works on 64-bit operands; in wrap mode the caller truncates to acc_w bits.
    function automatic logic signed [63:0] sat_add(
        input  logic signed [63:0] a,
        input  logic signed [63:0] b,
        input  int                 acc_w,
        input  logic               sat,
        output logic               ovf
    );
        logic signed [63:0] s;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        s     = a + b;
        ovf   = 1'b0;
        if (s > max_v) begin
            ovf = 1'b1;
            if (sat) s = max_v;
        end else if (s < min_v) begin
            ovf = 1'b1;
            if (sat) s = min_v;
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_mult_core.sv
// ============================================================================
// Module      : serial_mult_core
// Description : Signed activation x signed weight, one weight bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_mult_core
    import bsm_pkg::*;
#(
    parameter int ACT_W = 8,
    parameter int WGT_W = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start_i,
    input  logic [ACT_W-1:0]       act_i,
    input  logic [WGT_W-1:0]       wgt_i,
    input  logic [1:0]             prec_i,
    output logic                   done_o,
    output logic [ACT_W+WGT_W-1:0] product_o
);

    localparam int c_CW = $clog2(WGT_W);
    localparam int c_NW = c_CW + 1;
    localparam int c_HW = ACT_W + 1;
    localparam int c_PW = ACT_W + WGT_W;

    logic signed [ACT_W-1:0] act_q;
    logic [WGT_W-1:0]        wgt_q;
    logic [c_CW-1:0]         cnt_q;
    logic [c_NW-1:0]         nb_q;
    logic                    busy_q;
    logic signed [c_HW-1:0]  hi_q;
    logic [WGT_W-1:0]        lo_q;

    logic                    w_sign_bit;
    logic signed [c_HW-1:0]  w_pp;
    logic signed [c_HW-1:0]  w_base;
    logic signed [c_HW-1:0]  w_sum;
    logic [c_NW-1:0]         w_nb;

    assign w_nb       = c_NW'(nbits(prec_i, WGT_W));
    assign w_sign_bit = ({1'b0, cnt_q} == (nb_q - 1'b1));
    assign w_pp       = wgt_q[cnt_q] ? {act_q[ACT_W-1], act_q} : '0;
    assign w_base     = (cnt_q == '0) ? '0 : hi_q;
    assign w_sum      = w_sign_bit ? (w_base - w_pp) : (w_base + w_pp);
    assign done_o     = busy_q & w_sign_bit;

    // Result bits collect at the top of lo_q; shorter weights leave the product
    // scaled by 2^(WGT_W-nbits), removed here with a sign-preserving shift.
    assign product_o = c_PW'($signed({hi_q, lo_q}) >>> (c_NW'(WGT_W) - nb_q));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            act_q  <= '0;
            wgt_q  <= '0;
            cnt_q  <= '0;
            nb_q   <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (start_i) begin
            act_q  <= act_i;
            wgt_q  <= wgt_i;
            nb_q   <= w_nb;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (busy_q) begin
            hi_q  <= w_sum >>> 1;
            lo_q  <= {w_sum[0], lo_q[WGT_W-1:1]};
            cnt_q <= cnt_q + 1'b1;
            if (w_sign_bit) busy_q <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bit_serial_mac_ctrl.sv
// ============================================================================
// Module      : bit_serial_mac_ctrl
// Description : Bit-serial MAC with runtime weight precision and dot-product
//               accumulation behind valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serial_mac_ctrl
    import bsm_pkg::*;
#(
    parameter int ACT_W = 8,
    parameter int WGT_W = 8,
    parameter int ACC_W = 20,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACT_W-1:0] act,
    input  logic [WGT_W-1:0] wgt,
    input  logic [1:0]       prec,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_result,
    output logic             ovf
);

    localparam int c_PW = ACT_W + WGT_W;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;

    logic                    w_start;
    logic                    w_done;
    logic                    w_ovf;
    logic [c_PW-1:0]         w_product;

    assign w_start    = in_valid & in_ready;
    assign out_result = acc_q;
    assign ovf        = ovf_q;

    serial_mult_core #(
        .ACT_W (ACT_W),
        .WGT_W (WGT_W)
    ) u_core (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (w_start),
        .act_i     (act),
        .wgt_i     (wgt),
        .prec_i    (prec),
        .done_o    (w_done),
        .product_o (w_product)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        w_ovf     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rstn;
                if (in_valid && rstn) begin
                    last_d  = last;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (w_done) state_d = ACCUM;
            end
            ACCUM: begin
                acc_d   = ACC_W'(sat_add(64'(acc_q), 64'($signed(w_product)),
                                         ACC_W, SAT != 0, w_ovf));
                ovf_d   = ovf_q | w_ovf;
                state_d = last_q ? OUT : IDLE;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_mac_ctrl.sv
// ============================================================================
// Module      : tb_bit_serial_mac_ctrl
// Description : Self-checking bench for bit_serial_mac_ctrl (three configs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_mac_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_valid = 1'b0;
    logic       last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] act = '0;
    logic [7:0] wgt = '0;
    logic [1:0] prec = '0;

    logic               rdy0, rdy1, rdy2;
    logic               vld0, vld1, vld2;
    logic               ov0, ov1, ov2;
    logic signed [19:0] res0;
    logic signed [15:0] res1, res2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bit_serial_mac_ctrl #(.ACT_W(8), .WGT_W(8), .ACC_W(20), .SAT(1)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy0), .act(act), .wgt(wgt),
        .prec(prec), .last(last), .out_valid(vld0), .out_ready(out_ready),
        .out_result(res0), .ovf(ov0));

    bit_serial_mac_ctrl #(.ACT_W(8), .WGT_W(8), .ACC_W(16), .SAT(1)) u_sat16 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy1), .act(act), .wgt(wgt),
        .prec(prec), .last(last), .out_valid(vld1), .out_ready(out_ready),
        .out_result(res1), .ovf(ov1));

    bit_serial_mac_ctrl #(.ACT_W(8), .WGT_W(8), .ACC_W(16), .SAT(0)) u_wrap16 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy2), .act(act), .wgt(wgt),
        .prec(prec), .last(last), .out_valid(vld2), .out_ready(out_ready),
        .out_result(res2), .ovf(ov2));

    typedef struct {
        logic [7:0] a;
        logic [7:0] w;
        logic [1:0] p;
        longint     e;
        int         lat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Reference model: weight value from the low nbits, then plain integer MAC.
    function automatic int model_nbits(input logic [1:0] p);
        return (p == 2'b01) ? 4 : (p == 2'b10) ? 2 : 8;
    endfunction

    function automatic longint model_prod(input logic [7:0] a, input logic [7:0] w, input logic [1:0] p);
        int     n;
        longint v;
        n = model_nbits(p);
        v = longint'(w) & ((longint'(1) << n) - 1);
        if (v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
        return longint'($signed(a)) * v;
    endfunction

    function automatic void model_acc(inout longint acc, inout bit ovf_f, input longint p,
                                      input int width, input bit sat);
        longint m, hi, lo, s;
        m  = longint'(1) << width;
        hi = m / 2 - 1;
        lo = -(m / 2);
        s  = acc + p;
        if (s > hi || s < lo) begin
            ovf_f = 1'b1;
            if (sat) s = (s > hi) ? hi : lo;
            else     s = (s > hi) ? s - m : s + m;
        end
        acc = s;
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] w, input logic [1:0] p, input logic l);
        int b;
        b = 0;
        act = a; wgt = w; prec = p; last = l; in_valid = 1'b1;
        while (!rdy0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (b >= 200) timeout("accept");
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_shift", rdy0, 0);
        chk("in_ready_shift_sat16", rdy1, 0);
        chk("in_ready_shift_wrap16", rdy2, 0);
    endtask

    task automatic collect(input longint e0, input longint e1, input longint e2,
                           input bit o0, input bit o1, input bit o2, input int lat, input int stall);
        int k;
        k = 1;
        while (!vld0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, lat);
        chk("out_valid_sat16", vld1, 1);
        chk("out_valid_wrap16", vld2, 1);
        chk("result", res0, e0);
        chk("result_sat16", res1, e1);
        chk("result_wrap16", res2, e2);
        chk("ovf", ov0, o0);
        chk("ovf_sat16", ov1, o1);
        chk("ovf_wrap16", ov2, o2);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1; act = 8'h55; wgt = 8'h33; last = 1'b1;
            @(negedge clk);
            chk("stall_hold", res0, e0);
            chk("stall_valid", vld0, 1);
            chk("stall_in_ready", rdy0, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_clear", vld0, 0);
        chk("result_clear", res0, 0);
        chk("ovf_clear_wrap16", ov2, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'd3,   8'd5,   2'b00, 15,     10};
        tbl[1] = '{8'h80,  8'h80,  2'b00, 16384,  10};
        tbl[2] = '{8'd127, 8'hFF,  2'b00, -127,   10};
        tbl[3] = '{8'hFD,  8'hF7,  2'b01, -21,    6};
        tbl[4] = '{8'd5,   8'h0E,  2'b10, -10,    4};
        tbl[5] = '{8'd3,   8'd5,   2'b11, 15,     10};
        tbl[6] = '{8'h80,  8'h7F,  2'b00, -16256, 10};
        tbl[7] = '{8'h81,  8'h03,  2'b10, 127,    4};

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", rdy0, 0);
        chk("reset_out_valid", vld0, 0);
        chk("reset_result", res0, 0);
        chk("reset_ovf", ov0, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", rdy0, 1);

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].a, tbl[i].w, tbl[i].p, 1'b1);
            collect(tbl[i].e, tbl[i].e, tbl[i].e, 0, 0, 0, tbl[i].lat, 0);
        end

        send(8'd10, 8'd10, 2'b00, 1'b0);
        chk("no_early_valid", vld0, 0);
        send(8'hFB, 8'd4, 2'b00, 1'b0);
        chk("no_early_valid", vld0, 0);
        send(8'd7, 8'hFD, 2'b00, 1'b0);
        chk("no_early_valid", vld0, 0);
        send(8'd1, 8'd1, 2'b00, 1'b1);
        collect(60, 60, 60, 0, 0, 0, 10, 0);

        send(8'd127, 8'd127, 2'b00, 1'b0);
        send(8'd127, 8'd127, 2'b00, 1'b0);
        send(8'd127, 8'd127, 2'b00, 1'b1);
        collect(48387, 32767, -17149, 0, 1, 1, 10, 0);
        send(8'd2, 8'd2, 2'b00, 1'b1);
        collect(4, 4, 4, 0, 0, 0, 10, 0);

        send(8'd3, 8'd5, 2'b00, 1'b1);
        collect(15, 15, 15, 0, 0, 0, 10, 5);
        repeat (12) @(negedge clk);
        chk("stalled_input_ignored", vld0, 0);

        send(8'd100, 8'd100, 2'b00, 1'b0);
        send(8'd3, 8'd5, 2'b00, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("midshift_rst_valid", vld0, 0);
        chk("midshift_rst_result", res0, 0);
        chk("midshift_rst_in_ready", rdy0, 1);
        chk("midshift_rst_ovf", ov0, 0);
        repeat (12) @(negedge clk);
        chk("midshift_rst_abandoned", vld0, 0);
        send(8'd2, 8'd2, 2'b00, 1'b1);
        collect(4, 4, 4, 0, 0, 0, 10, 0);

        for (int t = 0; t < 40; t++) begin
            int         np;
            longint     a0, a1, a2;
            bit         f0, f1, f2;
            logic [7:0] ra, rw;
            logic [1:0] rp;
            longint     pr;
            np = $urandom_range(1, 4);
            a0 = 0; a1 = 0; a2 = 0;
            f0 = 1'b0; f1 = 1'b0; f2 = 1'b0;
            rp = 2'b00;
            for (int j = 0; j < np; j++) begin
                ra = 8'($urandom);
                rw = 8'($urandom);
                rp = 2'($urandom);
                pr = model_prod(ra, rw, rp);
                model_acc(a0, f0, pr, 20, 1'b1);
                model_acc(a1, f1, pr, 16, 1'b1);
                model_acc(a2, f2, pr, 16, 1'b0);
                send(ra, rw, rp, (j == np - 1));
            end
            collect(a0, a1, a2, f0, f1, f2, model_nbits(rp) + 2, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
